lvds_rx_lane_aligner: RTL and testbench

- Parametrised per-lane word-alignment controller for the source-synchronous LVDS camera receiver. Supersedes the single-word calibration loop.
- Trains every lane independently against its slice of a training pattern, issuing per-lane bitslip pulses to the deserialiser.
- Confirms lock over several consecutive words, and escalates to a timed PHY reset and retry budget when alignment fails.
- Sits between the DDR deserialiser and the AXIS packer; o_cal_done gates data into the packer.

---
 rtl/lvds_rx_lane_aligner.sv | 251 +++++++++++++++++++++++++
 tb/tb_lvds_rx_lane_aligner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
// Module      : lvds_rx_lane_aligner
// Description : Per-lane word-alignment controller for the LVDS camera
//               receiver. Trains each lane against its slice of a training
//               word with bitslip pulses, confirms lock over several words,
//               and escalates to a timed PHY reset with a retry budget.
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_rx_lane_aligner #(
  parameter int                           NUM_LANES     = 11,
  parameter int                           DESER         = 8,
  parameter logic [NUM_LANES*DESER-1:0]   CAL_PATTERN   = 88'h005A55FEDCBA9876543210,
  parameter int                           SETTLE_CYCLES = 16,
  parameter int                           LOCK_CONFIRM  = 4,
  parameter int                           MAX_SLIPS     = 32,
  parameter int                           RST_CYCLES    = 8,
  parameter int                           MAX_RETRIES   = 3
) (
  input  logic                         i_rx_sclk,
  input  logic                         rx_drst,
  input  logic                         i_rx_ready,
  input  logic [NUM_LANES*DESER-1:0]   i_rx_data,
  input  logic                         i_recal,
  output logic [NUM_LANES-1:0]         o_align,
  output logic                         o_phy_rst,
  output logic [NUM_LANES-1:0]         o_lane_lock,
  output logic                         o_cal_done,
  output logic                         o_cal_fail,
  output logic [2:0]                   o_state,
  output logic [7:0]                   o_retry_cnt
);

  localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int c_CONF_W   = $clog2(LOCK_CONFIRM + 1);
  localparam int c_SLIP_W   = $clog2(MAX_SLIPS + 1);
  localparam int c_RST_W    = $clog2(RST_CYCLES + 1);

  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CONF_W-1:0]   c_CONF_LAST   = c_CONF_W'(LOCK_CONFIRM - 1);
  localparam logic [c_SLIP_W-1:0]   c_SLIP_MAX    = c_SLIP_W'(MAX_SLIPS);
  localparam logic [c_RST_W-1:0]    c_RST_LOAD    = c_RST_W'(RST_CYCLES - 1);
  localparam logic [7:0]            c_RETRY_MAX   = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_PHYRST = 3'd5,
    S_FAILED = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [c_SETTLE_W-1:0]   settle_q, settle_d;
  logic [c_CONF_W-1:0]     confirm_q, confirm_d;
  logic [c_RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [NUM_LANES-1:0]    lock_q, lock_d;
  logic [NUM_LANES-1:0]    align_q, align_d;
  logic [c_SLIP_W-1:0]     slip_q [NUM_LANES];
  logic [c_SLIP_W-1:0]     slip_d [NUM_LANES];
  logic                    phy_rst_q, phy_rst_d;
  logic                    cal_done_q, cal_done_d;
  logic                    cal_fail_q, cal_fail_d;
  logic [7:0]              retry_q, retry_d;

  logic [NUM_LANES-1:0]    w_lane_match;
  logic [NUM_LANES-1:0]    w_lane_zero;
  logic [NUM_LANES-1:0]    w_slip_hit;
  logic                    w_abort;

  // Per-lane slice comparison against the training word.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign w_lane_match[k] = (i_rx_data[k*DESER +: DESER] == CAL_PATTERN[k*DESER +: DESER]);
    assign w_lane_zero[k]  = ~|i_rx_data[k*DESER +: DESER];
    assign w_slip_hit[k]   = (slip_q[k] == c_SLIP_MAX);
  end

  assign w_abort = ~i_rx_ready | i_recal;

  // Next-state and registered-output logic. The lane compare is evaluated on
  // the edge entering CHECK so that o_align and the lock update are visible
  // while o_state reads CHECK.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    confirm_d  = confirm_q;
    rst_cnt_d  = rst_cnt_q;
    lock_d     = lock_q;
    align_d    = '0;
    phy_rst_d  = 1'b0;
    cal_done_d = cal_done_q;
    cal_fail_d = cal_fail_q;
    retry_d    = retry_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      slip_d[k] = slip_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (i_rx_ready && !i_recal) begin
          state_d  = S_SETTLE;
          settle_d = c_SETTLE_LOAD;
        end
      end

      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_CHECK;
          for (int k = 0; k < NUM_LANES; k++) begin
            if (w_lane_match[k]) begin
              lock_d[k] = 1'b1;
            end else if (lock_q[k]) begin
              lock_d[k] = 1'b0;
            end else if (!w_lane_zero[k]) begin
              align_d[k] = 1'b1;
              if (slip_q[k] != c_SLIP_MAX) begin
                slip_d[k] = slip_q[k] + 1'b1;
              end
            end
          end
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      S_CHECK: begin
        if (&lock_q) begin
          state_d   = S_VERIFY;
          confirm_d = '0;
        end else if (|w_slip_hit) begin
          state_d   = S_PHYRST;
          phy_rst_d = 1'b1;
          rst_cnt_d = c_RST_LOAD;
          if (retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
          end
        end else begin
          state_d  = S_SETTLE;
          settle_d = c_SETTLE_LOAD;
        end
      end

      S_VERIFY: begin
        if (&w_lane_match) begin
          if (confirm_q == c_CONF_LAST) begin
            state_d    = S_DONE;
            cal_done_d = 1'b1;
          end else begin
            confirm_d = confirm_q + 1'b1;
          end
        end else begin
          lock_d   = '0;
          state_d  = S_SETTLE;
          settle_d = c_SETTLE_LOAD;
        end
      end

      S_DONE: begin
        // Holds until the global abort below.
      end

      S_PHYRST: begin
        if (rst_cnt_q == '0) begin
          lock_d = '0;
          for (int k = 0; k < NUM_LANES; k++) begin
            slip_d[k] = '0;
          end
          if ((MAX_RETRIES != 0) && (retry_q == c_RETRY_MAX)) begin
            state_d    = S_FAILED;
            cal_fail_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
          phy_rst_d = 1'b1;
        end
      end

      S_FAILED: begin
        if (i_recal) begin
          retry_d    = '0;
          cal_fail_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Loss of the deserialiser or a recal request restarts training from any
    // state except the PHY reset pulse and the sticky failure.
    if (w_abort && (state_q != S_PHYRST) && (state_q != S_FAILED)) begin
      state_d    = S_IDLE;
      lock_d     = '0;
      align_d    = '0;
      cal_done_d = 1'b0;
      confirm_d  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        slip_d[k] = '0;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_rx_sclk or posedge rx_drst) begin
    if (rx_drst) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      confirm_q  <= '0;
      rst_cnt_q  <= '0;
      lock_q     <= '0;
      align_q    <= '0;
      phy_rst_q  <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
      retry_q    <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        slip_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      confirm_q  <= confirm_d;
      rst_cnt_q  <= rst_cnt_d;
      lock_q     <= lock_d;
      align_q    <= align_d;
      phy_rst_q  <= phy_rst_d;
      cal_done_q <= cal_done_d;
      cal_fail_q <= cal_fail_d;
      retry_q    <= retry_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        slip_q[k] <= slip_d[k];
      end
    end
  end

  assign o_align     = align_q;
  assign o_phy_rst   = phy_rst_q;
  assign o_lane_lock = lock_q;
  assign o_cal_done  = cal_done_q;
  assign o_cal_fail  = cal_fail_q;
  assign o_state     = state_q;
  assign o_retry_cnt = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_rx_lane_aligner
// Description : Directed scoreboard bench for the LVDS lane aligner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_rx_lane_aligner;

  localparam int         NL  = 11;
  localparam logic [87:0] PAT = 88'h005A55FEDCBA9876543210;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic [87:0]   data;
  logic          recal;
  logic [NL-1:0] align;
  logic          phy_rst;
  logic [NL-1:0] lane_lock;
  logic          cal_done;
  logic          cal_fail;
  logic [2:0]    state;
  logic [7:0]    retry;

  lvds_rx_lane_aligner #(
    .NUM_LANES     (NL),
    .DESER         (8),
    .CAL_PATTERN   (PAT),
    .SETTLE_CYCLES (16),
    .LOCK_CONFIRM  (4),
    .MAX_SLIPS     (32),
    .RST_CYCLES    (8),
    .MAX_RETRIES   (3)
  ) dut (
    .i_rx_sclk   (clk),
    .rx_drst     (rst),
    .i_rx_ready  (ready),
    .i_rx_data   (data),
    .i_recal     (recal),
    .o_align     (align),
    .o_phy_rst   (phy_rst),
    .o_lane_lock (lane_lock),
    .o_cal_done  (cal_done),
    .o_cal_fail  (cal_fail),
    .o_state     (state),
    .o_retry_cnt (retry)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: cumulative per-lane slip pulses and pulses seen outside CHECK.
  int align_cnt [NL];
  int viol = 0;
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (align[k] === 1'b1) align_cnt[k] = align_cnt[k] + 1;
    end
    if ((align !== '0) && (state !== 3'd2)) viol = viol + 1;
  end

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = -1;
    end else begin
      e = sb.pop_front();
    end
    total++;
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edges_until_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (cal_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (state === s) begin
        ok = 1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_phy(input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (phy_rst === 1'b1) begin
        ok = 1;
        break;
      end
      step(1);
    end
  endtask

  task automatic pulse_recal();
    recal = 1'b1;
    step(1);
    recal = 1'b0;
  endtask

  function automatic logic [87:0] with_lane(input int k, input logic [7:0] v);
    logic [87:0] w;
    w = PAT;
    w[k*8 +: 8] = v;
    return w;
  endfunction

  initial begin : main
    int n, ok, t1, t2, cnt, w, diff;
    int snap [NL];

    rst = 1'b1; ready = 1'b0; data = '0; recal = 1'b0;
    t1 = 0; t2 = 0;
    step(3);
    push("rst_state", 0); push("rst_done", 0); push("rst_lock", 0);
    push("rst_retry", 0); push("rst_fail", 0); push("rst_phy", 0);
    pop_chk(int'(state)); pop_chk(int'(cal_done)); pop_chk(int'(lane_lock));
    pop_chk(int'(retry)); pop_chk(int'(cal_fail)); pop_chk(int'(phy_rst));
    rst = 1'b0;
    step(2);

    // Nominal lock with a clean pattern.
    data = PAT; ready = 1'b1;
    push("lat_nominal", 22);
    edges_until_done(100, n);
    pop_chk(n);
    push("lock_all", 'h7FF);  pop_chk(int'(lane_lock));
    push("retry_t1", 0);      pop_chk(int'(retry));
    push("state_done", 4);    step(5); pop_chk(int'(state));
    diff = 0;
    for (int k = 0; k < NL; k++) diff += align_cnt[k];
    push("align_t1", 0);      pop_chk(diff);

    // Recal from DONE drops done next cycle, then retrains.
    push("recal_done_low", 0); push("recal_idle", 0); push("recal_lat", 22);
    pulse_recal();
    pop_chk(int'(cal_done)); pop_chk(int'(state));
    edges_until_done(100, n);
    pop_chk(n);

    // Lane 3 rotated by two bits until its second slip.
    for (int k = 0; k < NL; k++) snap[k] = align_cnt[k];
    data = with_lane(3, 8'hD9);
    pulse_recal();
    cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (align[3] === 1'b1) begin
        cnt++;
        if (cnt == 1) t1 = i;
        if (cnt == 2) begin
          t2 = i;
          data = PAT;
          break;
        end
      end
    end
    push("l3_gap", 17);       pop_chk(t2 - t1);
    push("l3_done_seen", 1);
    edges_until_done(100, n);
    pop_chk((n > 0) ? 1 : 0);
    push("l3_pulses", 2);     pop_chk(align_cnt[3] - snap[3]);
    diff = 0;
    for (int k = 0; k < NL; k++) if (k != 3) diff += align_cnt[k] - snap[k];
    push("l3_others", 0);     pop_chk(diff);
    push("l3_lock", 'h7FF);   pop_chk(int'(lane_lock));

    // Corrupt one word in VERIFY after two matches.
    pulse_recal();
    push("reach_verify", 1);
    wait_state(3'd3, 100, ok);
    pop_chk(ok);
    step(2);
    push("verify_hold", 3);   pop_chk(int'(state));
    data = with_lane(7, 8'h00);
    step(1);
    data = PAT;
    push("vfy_settle", 1);    pop_chk(int'(state));
    push("vfy_unlock", 0);    pop_chk(int'(lane_lock));
    push("vfy_relock_lat", 21);
    edges_until_done(100, n);
    pop_chk(n);

    // Idle (all-zero) lane 5: never slipped, never locked, no PHY reset.
    for (int k = 0; k < NL; k++) snap[k] = align_cnt[k];
    data = with_lane(5, 8'h00);
    pulse_recal();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (phy_rst === 1'b1) cnt++;
    end
    push("l5_pulses", 0);       pop_chk(align_cnt[5] - snap[5]);
    push("l5_lock", 'h7DF);     pop_chk(int'(lane_lock));
    push("l5_phy", 0);          pop_chk(cnt);
    push("l5_cycling", 1);      pop_chk(((state === 3'd1) || (state === 3'd2)) ? 1 : 0);
    push("l5_done", 0);         pop_chk(int'(cal_done));

    // Lane 0 never matches: slips, PHY resets and finally sticky fail.
    for (int k = 0; k < NL; k++) snap[k] = align_cnt[k];
    data = with_lane(0, 8'hFF);
    pulse_recal();
    push("l0_phy_seen", 1);
    wait_phy(1000, ok);
    pop_chk(ok);
    push("l0_slips", 32);       pop_chk(align_cnt[0] - snap[0]);
    push("l0_retry1", 1);       pop_chk(int'(retry));
    w = 0;
    while ((phy_rst === 1'b1) && (w < 50)) begin
      w++;
      step(1);
    end
    push("l0_phy_width", 8);    pop_chk(w);
    push("l0_failed_seen", 1);
    wait_state(3'd6, 3000, ok);
    pop_chk(ok);
    push("l0_retry3", 3);       pop_chk(int'(retry));
    push("l0_fail", 1);         pop_chk(int'(cal_fail));
    push("l0_slips_all", 96);   pop_chk(align_cnt[0] - snap[0]);
    ready = 1'b0;
    step(3);
    push("fail_hold", 6);       pop_chk(int'(state));
    push("fail_recal_retry", 0); push("fail_recal_flag", 0); push("fail_recal_idle", 0);
    pulse_recal();
    pop_chk(int'(retry)); pop_chk(int'(cal_fail)); pop_chk(int'(state));

    // Asynchronous reset in the middle of a PHY reset pulse.
    ready = 1'b1;
    push("r_phy_seen", 1);
    wait_phy(1000, ok);
    pop_chk(ok);
    #2;
    rst = 1'b1;
    #1;
    push("r_phy_low", 0); push("r_state", 0); push("r_retry", 0);
    pop_chk(int'(phy_rst)); pop_chk(int'(state)); pop_chk(int'(retry));
    step(2);
    rst = 1'b0;
    step(1);

    push("no_stray_align", 0);  pop_chk(viol);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
